// File: rtl/pipe_stage_reg.sv
// Configurable inter-stage pipeline register with a valid bit, a NOP bubble,
// an exception freeze and saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 128,
  parameter int unsigned       STAT_W    = 2,
  parameter logic [STAT_W-1:0] STAT_AOK  = {STAT_W{1'b0}},
  parameter logic [3:0]        NOP_ICODE = 4'h1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [STAT_W-1:0] in_stat,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [STAT_W-1:0] out_stat,
  output logic [3:0]        out_icode,
  output logic [3:0]        out_ifun,
  output logic [DATA_W-1:0] out_data,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [2:0] {
    ACT_RESET  = 3'd0,
    ACT_STALL  = 3'd1,
    ACT_FROZEN = 3'd2,
    ACT_BUBBLE = 3'd3,
    ACT_LOAD   = 3'd4
  } act_e;

  // Counters stop at all-ones instead of wrapping so a long run never reads as short.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic              r_valid;
  logic [STAT_W-1:0] r_stat;
  logic [3:0]        r_icode;
  logic [3:0]        r_ifun;
  logic [DATA_W-1:0] r_data;
  logic              r_halted;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  act_e w_act;
  logic w_except;

  // Edge action decode: reset > stall > frozen > bubble > load.
  always_comb begin
    w_act    = ACT_LOAD;
    w_except = in_valid && (in_stat != STAT_AOK);
    if (!rst_n) begin
      w_act = ACT_RESET;
    end else if (stall) begin
      w_act = ACT_STALL;
    end else if (r_halted) begin
      w_act = ACT_FROZEN;
    end else if (bubble) begin
      w_act = ACT_BUBBLE;
    end else begin
      w_act = ACT_LOAD;
    end
  end

  // Stage contents and freeze flag.
  always_ff @(posedge clk) begin
    case (w_act)
      ACT_RESET, ACT_BUBBLE: begin
        r_valid <= 1'b0;
        r_stat  <= STAT_AOK;
        r_icode <= NOP_ICODE;
        r_ifun  <= 4'h0;
        r_data  <= {DATA_W{1'b0}};
        if (w_act == ACT_RESET) begin
          r_halted <= 1'b0;
        end
      end
      ACT_LOAD: begin
        r_valid <= in_valid;
        r_stat  <= in_stat;
        r_icode <= in_icode;
        r_ifun  <= in_ifun;
        r_data  <= in_data;
        if (w_except) begin
          r_halted <= 1'b1;
        end
      end
      ACT_STALL, ACT_FROZEN: begin
        r_valid <= r_valid;
      end
      default: begin
        r_valid <= r_valid;
      end
    endcase
  end

  // Performance counters; only reset clears them.
  always_ff @(posedge clk) begin
    case (w_act)
      ACT_RESET: begin
        r_stall_cnt  <= {CNT_W{1'b0}};
        r_bubble_cnt <= {CNT_W{1'b0}};
      end
      ACT_STALL: begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
      ACT_BUBBLE: begin
        r_bubble_cnt <= sat_inc(r_bubble_cnt);
      end
      default: begin
        r_stall_cnt <= r_stall_cnt;
      end
    endcase
  end

  assign out_valid  = r_valid;
  assign out_stat   = r_stat;
  assign out_icode  = r_icode;
  assign out_ifun   = r_ifun;
  assign out_data   = r_data;
  assign halted     = r_halted;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the PIPE datapath. It succeeds the fixed-width per-stage registers (F/D/E/M/W) with one configurable block, and adds:
- a valid bit;
- a fully defined bubble payload;
- an exception freeze;
- saturating stall and bubble performance counters.

One instance sits between each pair of pipeline stages. Pipeline control logic drives its stall and bubble inputs.

## Interface
Parameters:
- DATA_W, 128: width of the opaque payload (e.g. rA, rB, valC, valP packed by the instantiating stage).
- STAT_W, 2: width of the status field.
- STAT_AOK, 0: status encoding for "no exception".
- NOP_ICODE, 4'h1: icode loaded on bubble or reset.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  1  hold the current contents.
- bubble  in  1  replace the contents with a NOP.
- in_valid  in  1  upstream slot holds a real instruction.
- in_stat  in  STAT_W  upstream status.
- in_icode  in  4  upstream icode.
- in_ifun  in  4  upstream ifun.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  registered valid.
- out_stat  out  STAT_W  registered status.
- out_icode  out  4  registered icode.
- out_ifun  out  4  registered ifun.
- out_data  out  DATA_W  registered payload.
- halted  out  1  the stage is frozen on a latched exception.
- stall_cnt  out  CNT_W  cycles with stall=1, saturating.
- bubble_cnt  out  CNT_W  bubbles actually inserted, saturating.

## Operation
- The action each edge is chosen by priority: reset > stall > frozen > bubble > load.
- **Reset** (rst_n=0 at the edge):
  - out_valid=0, out_stat=STAT_AOK, out_icode=NOP_ICODE, out_ifun=0, out_data=0.
  - halted=0, stall_cnt=0, bubble_cnt=0.
  - Reset mid-operation discards the contents and any freeze in the same edge.
- **Stall** (stall=1):
  - All out_* and halted hold.
  - stall_cnt increments unless it is all-ones.
  - stall=1 with bubble=1 resolves as a stall. No bubble is inserted and bubble_cnt is unchanged.
- **Frozen** (halted=1, stall=0):
  - All out_* hold and bubble/load requests are ignored.
  - Neither counter changes.
- **Bubble** (stall=0, bubble=1, halted=0):
  - out_valid=0, out_stat=STAT_AOK, out_icode=NOP_ICODE, out_ifun=0, out_data=0.
  - bubble_cnt increments unless it is all-ones.
- **Load** (stall=0, bubble=0, halted=0): all out_* take the in_* values.
- **Freeze entry**:
  - halted becomes 1 at the edge where a load captures in_valid=1 and in_stat!=STAT_AOK.
  - halted stays 1 until reset.
  - A load with in_valid=0 and a non-AOK status does not freeze; the status is still captured.
- **Counters**: unsigned and saturating at 2^CNT_W-1; they never wrap. Both are cleared only by reset.
- There is no combinational path from any input to any output.

## Timing
- Load latency is 1 cycle: in_* sampled at edge N appear on out_* after edge N.
- Bubble: out_* show the NOP values after the edge that samples bubble=1.
- Stall: out_* keep the edge N-1 values through every stalled edge. Upstream must hold its own values; this block does not buffer the skipped input.
- halted rises in the same cycle that the excepting instruction appears on out_*.
- stall_cnt and bubble_cnt update at the same edge as the event they count.
- Reset takes effect at the first rising edge with rst_n=0. The first load can occur at the first edge with rst_n=1.

## Test plan
- **Reset then load**: assert rst_n=0 for 2 cycles, then release, apply in_valid=1, in_stat=0, in_icode=6, in_ifun=1, in_data=0x1234, stall=bubble=0. Required: all outputs are at reset values during reset; one edge later out_icode=6, out_ifun=1, out_data=0x1234, out_valid=1.
- **Stall hold plus counter**: load icode=3, then hold stall=1 for 5 edges while in_icode=7. Required: out_icode=3 throughout, stall_cnt=5, bubble_cnt=0.
- **Simultaneous stall and bubble**: drive stall=1 and bubble=1 for 1 edge, then stall=0, bubble=1 for 1 edge. Required: contents held after the first edge; after the second, out_icode=1, out_valid=0, out_data=0, bubble_cnt=1.
- **Exception freeze**: load in_valid=1, in_stat=2, icode=0, then apply loads of icode=6 and bubbles for 4 edges. Required: halted=1 from the capture edge, out_stat=2 and out_icode=0 held, bubble_cnt unchanged. A subsequent rst_n=0 clears halted.
- **Invalid non-AOK does not freeze**: load in_valid=0, in_stat=3. Required: out_stat=3, halted=0; the next load proceeds normally.
- **Saturation**: with CNT_W=4, hold stall=1 for 20 edges. Required: stall_cnt reaches 15 and stays there.
